// File: rtl/sram_access_sequencer.sv
// Sequences SRAM read/write cycles for the fetch and data ports of the CPU.
// The data port wins arbitration; every output except the stalls is registered.
module sram_access_sequencer #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WE_CYCLES = 1,
  parameter logic [1:0]  BANK      = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        if_stall,
  output logic        mem_stall,
  output logic        ram_en,
  output logic        ram_re,
  output logic        ram_we,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_SETUP, WR_STROBE, WR_HOLD, DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       port_mem;
  logic       accept_mem, accept_if, rd_last;
  logic       en_d, re_d, we_d, if_ready_d, mem_ready_d;

  assign accept_mem = (state == IDLE) && mem_req;
  assign accept_if  = (state == IDLE) && !mem_req && if_req;
  assign rd_last    = (state == RD_WAIT) && (cnt == 4'd0);

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

  // NOTE: state_next and cnt_next get defaults before the case so no path leaves them unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept_mem) begin
          state_next = mem_we ? WR_SETUP : RD_WAIT;
          cnt_next   = mem_we ? 4'd0 : RD_LOAD;
        end else if (accept_if) begin
          state_next = RD_WAIT;
          cnt_next   = RD_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) state_next = DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      WR_SETUP: begin
        state_next = WR_STROBE;
        cnt_next   = WE_LOAD;
      end
      WR_STROBE: begin
        if (cnt == 4'd0) state_next = WR_HOLD;
        else             cnt_next   = cnt - 4'd1;
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and ready are decoded from the upcoming state and then registered,
  // so they change only on the clock edge together with the state itself.
  always_comb begin
    en_d        = 1'b0;
    re_d        = 1'b0;
    we_d        = 1'b0;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    case (state_next)
      RD_WAIT: begin
        en_d = 1'b1;
        re_d = 1'b1;
      end
      WR_SETUP, WR_HOLD: en_d = 1'b1;
      WR_STROBE: begin
        en_d = 1'b1;
        we_d = 1'b1;
      end
      DONE: begin
        if_ready_d  = !port_mem;
        mem_ready_d = port_mem;
      end
      default: ;
    endcase
  end

  // NOTE: every register here uses non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      port_mem  <= 1'b0;
      ram_en    <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      ram_addr  <= 18'd0;
      ram_wdata <= 16'd0;
      if_rdata  <= 16'd0;
      mem_rdata <= 16'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ram_en    <= en_d;
      ram_re    <= re_d;
      ram_we    <= we_d;
      if_ready  <= if_ready_d;
      mem_ready <= mem_ready_d;
      if (accept_mem || accept_if) begin
        port_mem <= accept_mem;
        ram_addr <= {BANK, accept_mem ? mem_addr : if_addr};
        if (accept_mem && mem_we) ram_wdata <= mem_wdata;
      end
      if (rd_last) begin
        if (port_mem) mem_rdata <= ram_rdata;
        else          if_rdata  <= ram_rdata;
      end
    end
  end

endmodule
